// File: rtl/kudu_branch_trace_buf.sv
// Two-lane branch trace capture FIFO draining one record per cycle, with saturating stats counters.
// Latency 1 cycle push-to-head; sink backpressure fills the FIFO, overflow drops. Macro: KUDU_BRANCH_TRACE_MISS_ONLY_EN.
module kudu_branch_trace_buf #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_stop_i,
    input  logic [1:0]               br_valid_i,
    input  logic [1:0]               br_taken_i,
    input  logic [1:0]               br_miss_i,
    input  logic [31:0]              br_pc0_i,
    input  logic [31:0]              br_pc1_i,
    input  logic [31:0]              br_tgt0_i,
    input  logic [31:0]              br_tgt1_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_pc_o,
    output logic [31:0]              out_tgt_o,
    output logic                     out_taken_o,
    output logic                     out_miss_o,
    output logic                     out_fwd_o,
    output logic                     capture_en_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         cnt_branch_o,
    output logic [CNT_W-1:0]         cnt_miss_o,
    output logic [CNT_W-1:0]         cnt_drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic        miss;
    } rec_t;

    rec_t              mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr1;
    logic [LW-1:0]     level_q, level_d, free;
    logic              capture_en_q, capture_en_d;
    logic [CNT_W-1:0]  cnt_branch_q, cnt_branch_d;
    logic [CNT_W-1:0]  cnt_miss_q, cnt_miss_d;
    logic [CNT_W-1:0]  cnt_drop_q, cnt_drop_d;

    logic              pop;
    logic [1:0]        cnt_lanes, elig;
    logic [1:0]        n_elig, n_push, n_drop, n_br, n_miss;
    logic              we0, we1;
    rec_t              lane0, lane1, rec0, rec1, head;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_comb begin
        lane0 = '{pc: br_pc0_i, tgt: br_tgt0_i, taken: br_taken_i[0], miss: br_miss_i[0]};
        lane1 = '{pc: br_pc1_i, tgt: br_tgt1_i, taken: br_taken_i[1], miss: br_miss_i[1]};

        // Gating uses the registered enable, so a toggle cycle sees the old state.
        pop       = (level_q != '0) & out_ready_i;
        cnt_lanes = {2{capture_en_q}} & br_valid_i;
`ifdef KUDU_BRANCH_TRACE_MISS_ONLY_EN
        elig      = cnt_lanes & br_miss_i;
`else
        elig      = cnt_lanes;
`endif
        n_elig = {1'b0, elig[0]} + {1'b0, elig[1]};
        n_br   = {1'b0, cnt_lanes[0]} + {1'b0, cnt_lanes[1]};
        n_miss = {1'b0, cnt_lanes[0] & br_miss_i[0]} + {1'b0, cnt_lanes[1] & br_miss_i[1]};

        // A same-cycle pop frees a slot for this cycle's push.
        free = LW'(DEPTH) - level_q + {{AW{1'b0}}, pop};
        if (free >= {{(LW-2){1'b0}}, n_elig}) begin
            n_push = n_elig;
        end else begin
            n_push = free[1:0];
        end
        n_drop = n_elig - n_push;

        rec0    = elig[0] ? lane0 : lane1;
        rec1    = lane1;
        we0     = (n_push != 2'd0);
        we1     = (n_push == 2'd2);
        wr_ptr1 = wr_ptr_q + AW'(1);

        wr_ptr_d     = wr_ptr_q + AW'(n_push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        level_d      = level_q + LW'(n_push) - LW'(pop);
        capture_en_d = capture_en_q ^ start_stop_i;

        if (start_stop_i && !capture_en_q) begin
            cnt_branch_d = '0;
            cnt_miss_d   = '0;
            cnt_drop_d   = '0;
        end else begin
            cnt_branch_d = sat_add(cnt_branch_q, n_br);
            cnt_miss_d   = sat_add(cnt_miss_q, n_miss);
            cnt_drop_d   = sat_add(cnt_drop_q, n_drop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            capture_en_q <= 1'b0;
            cnt_branch_q <= '0;
            cnt_miss_q   <= '0;
            cnt_drop_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            capture_en_q <= capture_en_d;
            cnt_branch_q <= cnt_branch_d;
            cnt_miss_q   <= cnt_miss_d;
            cnt_drop_q   <= cnt_drop_d;
        end
    end

    // Storage is deliberately left unreset; valid is derived from level only.
    always_ff @(posedge clk_i) begin
        if (we0) mem_q[wr_ptr_q] <= rec0;
        if (we1) mem_q[wr_ptr1]  <= rec1;
    end

    always_comb begin
        head         = mem_q[rd_ptr_q];
        out_valid_o  = (level_q != '0);
        out_pc_o     = head.pc;
        out_tgt_o    = head.tgt;
        out_taken_o  = head.taken;
        out_miss_o   = head.miss;
        out_fwd_o    = (head.tgt > head.pc);
        capture_en_o = capture_en_q;
        level_o      = level_q;
        cnt_branch_o = cnt_branch_q;
        cnt_miss_o   = cnt_miss_q;
        cnt_drop_o   = cnt_drop_q;
    end

endmodule
